// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the synchronous FIFO family.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   clog2(v)               : ceil(log2(v)), elaboration-time only
//   ptr_w(depth)           : read/write pointer width
//   cnt_w(depth)           : occupancy counter width (must hold 0..depth)
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // A 1-entry memory still needs a 1-bit address.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  // One extra bit so that a full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for the FIFO.
//   clk   : clock
//   rst   : async active-low reset, clears only the read register
//   we    : write enable; wdata stored at waddr on the rising edge
//   re    : read enable; mem[raddr] captured into rdata on the rising edge
//   rdata : registered read data, holds its value when re is low
// The array itself is not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // The owner never reads and writes the same slot in one cycle: a read
  // needs a non-empty FIFO, and then the write slot is always a free one.
  always_ff @(posedge clk or negedge rst)
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds and a read-valid strobe.
//   clk          : clock, all state changes on the rising edge
//   rst          : async active-low reset
//   wr / din     : write request / data (accepted when not full)
//   rd           : read request (accepted when not empty)
//   dout         : registered read data, 1-cycle latency
//   dout_valid   : high the cycle after an accepted read
//   full, empty  : count == DEPTH, count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : stored entries, 0..DEPTH
//   overflow     : sticky wr-while-full   (SYNC_FIFO_ERR_FLAGS_EN, else 0)
//   underflow    : sticky rd-while-empty  (SYNC_FIFO_ERR_FLAGS_EN, else 0)
// DEPTH must be a power of two, at least 2, so the pointers wrap for free.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic          wr_acc, rd_acc;

  // Acceptance uses the flags decoded from the registered count, so a full
  // FIFO drops a same-cycle write even though a read frees a slot, and an
  // empty FIFO never bypasses din to dout.
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dout_valid <= rd_acc;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (dout)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky until reset; flagged on the raw request, not the accepted one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr && full)  ovf_q <= 1'b1;
      if (rd && empty) udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int CW     = 5;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr  = 1'b0;
  logic              rd  = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0]     count;
  logic              overflow, underflow;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a queue of stored words plus the observable registers.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_dv   = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_udf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ".count"},  32'(count),        32'(n));
    chk({ph, ".full"},   32'(full),         32'(n == DEPTH));
    chk({ph, ".empty"},  32'(empty),        32'(n == 0));
    chk({ph, ".afull"},  32'(almost_full),  32'(n >= AF));
    chk({ph, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({ph, ".dv"},     32'(dout_valid),   32'(m_dv));
    chk({ph, ".dout"},   32'(dout),         32'(m_dout));
    chk({ph, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({ph, ".udf"},    32'(underflow),    32'(m_udf));
  endtask

  task automatic model_clear();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock: drive at negedge, predict from the pre-edge occupancy,
  // sample 1 ns after the rising edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input string ph);
    bit wa, ra;
    @(negedge clk);
    wr = w; din = d; rd = r;
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    if (ERR_EN && w && q.size() == DEPTH) m_ovf = 1'b1;
    if (ERR_EN && r && q.size() == 0)     m_udf = 1'b1;
    @(posedge clk);
    #1;
    m_dv = ra;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    chk_all(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    #1;
    model_clear();
    chk_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    // Fill to full, reject a 17th write, drain in order.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, "fill");
    step(1'b1, 8'hAA, 1'b0, "wr_full");
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
    step(1'b0, '0, 1'b0, "idle");

    // Simultaneous read/write at 5 entries across the pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h30 + i), 1'b0, "pre5");
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'($urandom), 1'b1, "wrap");
    step(1'b0, '0, 1'b0, "wrap_idle");

    // Full with wr=rd: read taken, write dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0, "fill2");
    step(1'b1, 8'h55, 1'b1, "full_wr_rd");
    while (q.size() > 0) step(1'b0, '0, 1'b1, "drain2");
    step(1'b0, '0, 1'b0, "idle2");
    // Empty with wr=rd: write taken, no bypass.
    step(1'b1, 8'h66, 1'b1, "empty_wr_rd");
    step(1'b0, '0, 1'b1, "rd_66");
    step(1'b0, '0, 1'b0, "idle3");

    // Underflow sticky through later valid traffic.
    do_reset();
    step(1'b0, '0, 1'b1, "udf");
    for (int i = 0; i < 6; i++) step(1'b1, DATA_W'(i + 1), (i > 2), "udf_traffic");
    step(1'b0, '0, 1'b0, "udf_hold");

    // Asynchronous reset mid-burst with count 9 and dout_valid high.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(8'h70 + i), 1'b0, "burst");
    step(1'b1, 8'h7A, 1'b1, "burst_rw");
    step(1'b0, '0, 1'b1, "burst_rd");
    chk("pre_rst.count", 32'(count), 32'd9);
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; din = 8'hEE;
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    chk("async.count", 32'(count),      32'd0);
    chk("async.empty", 32'(empty),      32'd1);
    chk("async.dv",    32'(dout_valid), 32'd0);
    chk_all("async");
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b1, "post_rst_rd");
    step(1'b0, '0, 1'b0, "post_rst_idle");

    // Randomised traffic with shifting write/read bias.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      pw = (ph == 0) ? 80 : (ph == 1) ? 50 : (ph == 2) ? 20 : 60;
      for (int i = 0; i < 100; i++)
        step(($urandom_range(99) < pw), DATA_W'($urandom),
             ($urandom_range(99) < (100 - pw)), "rand");
    end
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO. This is the next generation of the team's 8x16 FIFO.
- Generalised in data width and depth.
- Adds true simultaneous read/write, an occupancy count, programmable almost-full/almost-empty thresholds and a read-valid strobe.
- Sits between a producer and a consumer in the same clock domain and is the standard buffer for datapath blocks.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised upstream.
- wr  input  1  write request.
- din  input  DATA_W  write data, sampled when a write is accepted.
- rd  input  1  read request.
- dout  output  DATA_W  registered read data.
- dout_valid  output  1  high for one cycle when dout carries newly read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky write-when-full error (see Optional Feature).
- underflow  output  1  sticky read-when-empty error (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous) sets:
  - wptr, rptr, count, dout to 0 and dout_valid to 0;
  - empty = 1, full = 0, almost_empty = 1;
  - almost_full = (AF_LEVEL == 0);
  - overflow and underflow to 0.
- Memory contents are not reset.
- Reset mid-operation aborts everything in flight; all stored data is discarded.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_acc = wr && !full. Read acceptance: rd_acc = rd && !empty. Both use the flags as registered at the start of the cycle.
- An accepted write stores din at mem[wptr] and increments wptr.
- An accepted read captures mem[rptr] into dout on the same edge and increments rptr. dout_valid is 1 in the following cycle, giving a read latency of 1 clock.
- Count update per cycle:
  - only wr_acc: count + 1;
  - only rd_acc: count - 1;
  - both: count unchanged and both pointers advance;
  - neither: no change.
- Boundary cases:
  - Full with wr and rd: only the read is accepted and the write is dropped. count drops to DEPTH-1.
  - Empty with wr and rd: only the write is accepted; there is no bypass. dout and dout_valid are unaffected.
  - A rejected request changes no state: pointers, count and memory are untouched.
- Without an accepted read, dout holds its last value and dout_valid is 0.
- All flags are combinational decodes of the registered count. They therefore reflect an operation the cycle after it is accepted.
- No state machine. State is held in two pointers, the counter and the output register.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with wr && full;
  - underflow sets on any cycle with rd && empty;
  - both are sticky and cleared only by reset.
- Undefined: both ports remain present and are tied to 0, keeping the interface stable. No error logic is synthesised.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 function and the pointer/count width derivation;
  - default DATA_W and DEPTH constants.
- Sub-module fifo_ram: simple dual-port memory with one write port and a registered read port. It is parametrised by DATA_W and DEPTH and instantiated once.
- Pointers, counter and flags live in the top level.

Test Plan:
All scenarios use DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- Reset release, then write 0x01..0x10 (16 writes) followed by 16 reads:
  - full=1 after the 16th write; a 17th write of 0xAA is dropped;
  - reads return 0x01..0x10 in order, each with dout_valid one cycle after rd;
  - empty=1 at the end.
- Thresholds: count 2 → almost_empty=1; count 3 → 0; count 14 → almost_full=1; count 13 → 0.
- With 5 entries, hold wr=rd=1 for 20 cycles:
  - count stays 5 and pointers wrap;
  - output order is preserved across the wrap.
- Full with wr=rd=1: the read is accepted, din is dropped and count becomes 15. Empty with wr=rd=1: din is stored, count becomes 1 and dout_valid stays 0.
- Drive rst low asynchronously mid-burst with count=9:
  - count=0, empty=1 and dout_valid=0 immediately, without waiting for a clock edge;
  - the next read after release is ignored.
- SYNC_FIFO_ERR_FLAGS_EN defined: rd while empty → underflow=1, which stays set through later valid traffic until rst. Macro undefined: overflow and underflow stay 0.
